// File: rtl/hls_start_pkg.sv
// ============================================================================
// hls_start_pkg : shared types, mode constants and width helper for the
//                 HLS start sequencer.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package hls_start_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } chan_state_t;

    localparam int MODE_LEVEL = 0;
    localparam int MODE_HS    = 1;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int clog2w(input int unsigned v);
        int w;
        w = 1;
        while ((32'd1 << w) < v) w++;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hls_start_chan.sv
// ============================================================================
// hls_start_chan : per-channel ap_start FSM (level or ap_ctrl_hs handshake).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module hls_start_chan
    import hls_start_pkg::*;
#(
    parameter int MODE = MODE_LEVEL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        ap_ready,
    input  logic        ap_done,
    input  logic        auto_restart,
    output logic        ap_start,
    output chan_state_t state
);

    chan_state_t r_state;
    chan_state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT:  if (go) w_next = ST_START;
            // Level mode never leaves START; handshake waits for ap_ready.
            ST_START: if ((MODE == MODE_HS) && ap_ready) w_next = ST_RUN;
            ST_RUN:   if (ap_done) w_next = auto_restart ? ST_START : ST_DONE;
            ST_DONE:  w_next = ST_DONE;
            default:  w_next = ST_WAIT;
        endcase
    end

    always_comb begin
        ap_start = (r_state == ST_START);
        state    = r_state;
    end

endmodule

`default_nettype wire

// File: rtl/hls_start_seq.sv
// ============================================================================
// hls_start_seq : staggered post-reset ap_start sequencer for NUM_CH HLS cores.
//                 Optional start counter when HLS_START_SEQ_STATS_EN is defined.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module hls_start_seq
    import hls_start_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int INIT_DELAY = 3,
    parameter int STAGGER    = 2,
    parameter int MODE       = MODE_LEVEL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              auto_restart,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
`ifdef HLS_START_SEQ_STATS_EN
    output logic [15:0]       start_cnt,
`endif
    output logic [NUM_CH-1:0] ap_start,
    output logic              all_started,
    output logic              busy
);

    localparam int c_t_last = INIT_DELAY + (NUM_CH - 1) * STAGGER + 1;
    localparam int c_cnt_w  = clog2w(c_t_last + 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [NUM_CH-1:0]  w_go;
    chan_state_t        w_state [NUM_CH];
    logic               r_all_started;
    logic               w_none_wait;

    // Saturates one past the last threshold so no compare can fire twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (enable && (r_cnt != c_cnt_w'(c_t_last)))
            r_cnt <= r_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int c_thr = INIT_DELAY + i * STAGGER;

        assign w_go[i] = enable && (r_cnt == c_cnt_w'(c_thr));

        hls_start_chan #(
            .MODE (MODE)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .go           (w_go[i]),
            .ap_ready     (ap_ready[i]),
            .ap_done      (ap_done[i]),
            .auto_restart (auto_restart),
            .ap_start     (ap_start[i]),
            .state        (w_state[i])
        );
    end

    always_comb begin
        w_none_wait = 1'b1;
        busy        = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_state[k] == ST_WAIT) w_none_wait = 1'b0;
            if ((w_state[k] == ST_START) || (w_state[k] == ST_RUN)) busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_all_started <= 1'b0;
        else        r_all_started <= r_all_started | w_none_wait;
    end

    assign all_started = r_all_started;

`ifdef HLS_START_SEQ_STATS_EN
    logic [NUM_CH-1:0] w_enter;
    logic [4:0]        w_pop;
    logic [16:0]       w_sum;
    logic [15:0]       r_start_cnt;

    // Mirrors the channel transitions into START so they count on the same edge.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_enter[k] = ((w_state[k] == ST_WAIT) && w_go[k]) ||
                         ((MODE == MODE_HS) && (w_state[k] == ST_RUN) &&
                          ap_done[k] && auto_restart);
            w_pop = w_pop + 5'(w_enter[k]);
        end
        w_sum = {1'b0, r_start_cnt} + 17'(w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_start_cnt <= '0;
        else
            r_start_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end

    assign start_cnt = r_start_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hls_start_seq.sv
// ============================================================================
// tb_hls_start_seq : directed bench for hls_start_seq (level and handshake).
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_hls_start_seq;

    logic       clk = 1'b0;
    logic       rst_n_l = 1'b0;
    logic       rst_n_h = 1'b0;
    logic       enable_l = 1'b1;
    logic       enable_h = 1'b1;
    logic       auto_h = 1'b1;
    logic [3:0] ready_h = '0;
    logic [3:0] done_h = '0;
    logic [3:0] start_l, start_h;
    logic       all_l, all_h, busy_l, busy_h;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef HLS_START_SEQ_STATS_EN
    logic [15:0] cnt_l, cnt_h, cnt_s;
    logic [3:0]  start_s;
    logic        all_s, busy_s;
`endif

    hls_start_seq #(.NUM_CH(4), .INIT_DELAY(3), .STAGGER(2), .MODE(0)) u_lvl (
        .clk          (clk),
        .rst_n        (rst_n_l),
        .enable       (enable_l),
        .auto_restart (1'b0),
        .ap_ready     (4'b0000),
        .ap_done      (4'b0000),
`ifdef HLS_START_SEQ_STATS_EN
        .start_cnt    (cnt_l),
`endif
        .ap_start     (start_l),
        .all_started  (all_l),
        .busy         (busy_l)
    );

    hls_start_seq #(.NUM_CH(4), .INIT_DELAY(3), .STAGGER(2), .MODE(1)) u_hs (
        .clk          (clk),
        .rst_n        (rst_n_h),
        .enable       (enable_h),
        .auto_restart (auto_h),
        .ap_ready     (ready_h),
        .ap_done      (done_h),
`ifdef HLS_START_SEQ_STATS_EN
        .start_cnt    (cnt_h),
`endif
        .ap_start     (start_h),
        .all_started  (all_h),
        .busy         (busy_h)
    );

`ifdef HLS_START_SEQ_STATS_EN
    hls_start_seq #(.NUM_CH(4), .INIT_DELAY(3), .STAGGER(0), .MODE(0)) u_st (
        .clk          (clk),
        .rst_n        (rst_n_l),
        .enable       (enable_l),
        .auto_restart (1'b0),
        .ap_ready     (4'b0000),
        .ap_done      (4'b0000),
        .start_cnt    (cnt_s),
        .ap_start     (start_s),
        .all_started  (all_s),
        .busy         (busy_s)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp4;
        int         st_edge [4];

        // Reset state of both instances.
        tick();
        chk("rst_lvl_start", 16'(start_l), 16'h0);
        chk("rst_lvl_all",   16'(all_l),   16'h0);
        chk("rst_lvl_busy",  16'(busy_l),  16'h0);
        chk("rst_hs_start",  16'(start_h), 16'h0);

        // Level mode: starts at edges 3,5,7,9; all_started from edge 10.
        rst_n_l = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            tick();
            for (int i = 0; i < 4; i++) exp4[i] = (e >= 3 + 2 * i);
            chk("lvl_start", 16'(start_l), 16'(exp4));
            chk("lvl_all",   16'(all_l),   16'(e >= 10));
            chk("lvl_busy",  16'(busy_l),  16'(e >= 3));
`ifdef HLS_START_SEQ_STATS_EN
            chk("stats_cnt", cnt_s, (e >= 3) ? 16'd4 : 16'd0);
`endif
        end

        // Enable low for edges 4..8: ch1..ch3 slide to edges 10, 12, 14.
        rst_n_l = 1'b0;
        tick();
        chk("lvl_rst2_start", 16'(start_l), 16'h0);
        rst_n_l = 1'b1;
        st_edge = '{3, 10, 12, 14};
        for (int e = 0; e <= 15; e++) begin
            enable_l = !((e >= 4) && (e <= 8));
            tick();
            for (int i = 0; i < 4; i++) exp4[i] = (e >= st_edge[i]);
            chk("en_start", 16'(start_l), 16'(exp4));
            chk("en_all",   16'(all_l),   16'(e >= 15));
        end
        enable_l = 1'b1;

        // Handshake mode.
        rst_n_h = 1'b1;
        tick(); tick(); tick();                                   // edge 2
        chk("hs_e2", 16'(start_h), 16'h0);
        tick(); chk("hs_e3", 16'(start_h), 16'h1);               // ch0 rises
        tick(); chk("hs_e4", 16'(start_h), 16'h1);
        tick(); chk("hs_e5", 16'(start_h), 16'h3);               // ch1 rises
        ready_h = 4'b0001;
        tick(); chk("hs_ready0", 16'(start_h), 16'h2);           // ch0 high 3 cycles
        chk("hs_busy", 16'(busy_h), 16'h1);
        ready_h = 4'b0010;
        tick(); chk("hs_e7", 16'(start_h), 16'h4);               // ch1 RUN, ch2 rises
        ready_h = 4'b0000;
        done_h  = 4'b0010;
        tick(); chk("hs_restart", 16'(start_h), 16'h6);          // ch1 re-issued
        done_h  = 4'b0000;
        tick(); chk("hs_e9", 16'(start_h), 16'hE);               // ch3 rises
        ready_h = 4'b0010;
        tick(); chk("hs_e10", 16'(start_h), 16'hC);
        chk("hs_all_e10", 16'(all_h), 16'h1);
        ready_h = 4'b0000;
        auto_h  = 1'b0;
        done_h  = 4'b0010;
        tick(); chk("hs_done", 16'(start_h), 16'hC);             // ch1 to DONE
        auto_h  = 1'b1;
        tick(); chk("hs_done_sticky", 16'(start_h), 16'hC);
        done_h  = 4'b0100;
        ready_h = 4'b0100;
        tick(); chk("hs_rdy_done", 16'(start_h), 16'h8);         // ch2 RUN, done ignored
        done_h  = 4'b0000;
        ready_h = 4'b0000;
        tick(); chk("hs_run_hold", 16'(start_h), 16'h8);
        chk("hs_busy_run", 16'(busy_h), 16'h1);
        done_h  = 4'b0100;
        tick(); chk("hs_restart2", 16'(start_h), 16'hC);
        done_h  = 4'b0000;

        // Asynchronous reset between edges.
        #3;
        rst_n_h = 1'b0;
        #1;
        chk("arst_start", 16'(start_h), 16'h0);
        chk("arst_busy",  16'(busy_h),  16'h0);
        chk("arst_all",   16'(all_h),   16'h0);
        tick();
        rst_n_h = 1'b1;
        tick(); tick(); tick();
        chk("replay_e2", 16'(start_h), 16'h0);
        tick();
        chk("replay_e3", 16'(start_h), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hls_start_seq.md
Name: hls_start_seq

Overview:
- Parametrised start sequencer for HLS cores in the memcached pipeline.
- Drives ap_start for NUM_CH cores after a programmable post-reset delay, staggering the channels by a fixed number of cycles.
- Two modes: level (start held high forever) and ap_ctrl_hs handshake, with optional auto-restart on ap_done.
- Sits between the reset/clock block and the HLS kernels; replaces the fixed 3-state start generator.

Parameters:
- NUM_CH, 4, number of HLS cores driven (1..16).
- INIT_DELAY, 3, edges from the first enabled edge until channel 0 starts (0..255).
- STAGGER, 2, extra edges between consecutive channel starts (0..255).
- MODE, 0, 0 = level mode, 1 = handshake mode (ap_ctrl_hs).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- enable  in  1  sequencer run; low freezes the delay counter.
- auto_restart  in  1  handshake mode only: re-issue start after ap_done.
- ap_ready  in  NUM_CH  per-core ap_ready.
- ap_done  in  NUM_CH  per-core ap_done.
- ap_start  out  NUM_CH  per-core start.
- all_started  out  1  every channel has left WAIT.
- busy  out  1  OR of all channels in START or RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ap_start, all_started and busy go to 0 immediately.
  - Counter goes to 0; every channel goes to WAIT.
  - Applies equally to a reset asserted mid-operation.
- Delay counter:
  - Width CNT_W = clog2(INIT_DELAY + (NUM_CH-1)*STAGGER + 2).
  - Increments on each rising edge with enable=1; holds when enable=0.
  - Saturates at T_LAST = INIT_DELAY + (NUM_CH-1)*STAGGER + 1 and never wraps.
- Start threshold: T_i = INIT_DELAY + i*STAGGER. Edge 0 is the first edge with rst_n=1 and enable=1.
- Channel FSM, one per channel, states WAIT, START, RUN, DONE:
  - WAIT: ap_start=0. Go to START at the edge where the counter equals T_i with enable=1. ap_start[i] is registered high at that same edge.
  - Level mode (MODE=0): START is terminal, ap_start held 1. ap_ready and ap_done are ignored. RUN and DONE are unreachable.
  - Handshake mode (MODE=1), START: ap_start=1 until ap_ready[i] is sampled 1, then go to RUN. ap_start drops at that edge.
  - START with ap_ready=1 and ap_done=1 in the same cycle: go to RUN. ap_done is not consumed.
  - RUN: ap_start=0. On ap_done[i]=1 go to START if auto_restart=1 (ap_start high the following cycle), else go to DONE.
  - DONE: terminal until reset, ap_start=0.
- Enable:
  - enable=0 affects only channels still in WAIT.
  - Channels in START, RUN or DONE continue regardless.
- STAGGER=0: all channels start on the same edge.
- INIT_DELAY=0: channel 0 starts at edge 0.
- all_started: registered; 1 once no channel is in WAIT, sticky until reset.
- busy: combinational from the channel state registers.
- Status outputs follow the channel registers with no added latency.

Optional Feature:
- Macro HLS_START_SEQ_STATS_EN.
- Defined:
  - Adds output start_cnt, 16 bits.
  - Counts every WAIT->START and RUN->START transition across all channels, saturating at 0xFFFF.
  - Several simultaneous transitions add their population count in the same cycle.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package hls_start_pkg holds:
  - the channel state enum (WAIT, START, RUN, DONE), 2 bits;
  - mode constants MODE_LEVEL=0 and MODE_HS=1;
  - a clog2-based width helper.
- Sub-module hls_start_chan: one channel FSM, instantiated NUM_CH times via generate.
  - Inputs: go, ap_ready, ap_done, auto_restart.
  - Outputs: ap_start and state.
- The top level holds the counter, the threshold compares, the aggregation logic and the optional statistics counter.

Test Plan:
- Defaults, MODE=0, enable tied 1, release rst_n -> ap_start[0..3] rise at edges 3, 5, 7, 9 and stay high; all_started=1 from edge 10.
- MODE=1, ap_ready[0] pulsed 2 cycles after ap_start[0] rises -> ap_start[0] high exactly 3 cycles; ch0 in RUN, busy=1.
- MODE=1, auto_restart=1, ap_done[1] pulsed in RUN -> ap_start[1] high the next cycle. With auto_restart=0 -> ap_start[1] stays 0 permanently (DONE).
- enable dropped at edge 4 for 5 cycles -> ch0 already high; ch1 start slides from edge 5 to edge 10, ch3 to edge 14.
- rst_n asserted asynchronously mid-clock while channels are in RUN -> ap_start, busy and all_started go 0 before the next edge; the sequence replays from edge 0 after release.
- HLS_START_SEQ_STATS_EN, STAGGER=0, MODE=0, NUM_CH=4 -> start_cnt goes 0 to 4 in a single cycle at edge 3.
